// File: rtl/controller_pkg.sv
// Shared types and constants for the serial game-controller responder.
// State encoding, bits per controller and the button bit positions.
package controller_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  localparam int BUTTONS_PER_CONTROLLER = 8;

  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

endpackage

// File: rtl/sync_edge_detect_m.sv
// Multi-flop synchronizer for an asynchronous host line,
// with a one-cycle rise/fall pulse taken from an edge-detect flop.
module sync_edge_detect_m #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/controller_responder.sv
// Device side of the serial controller protocol: N 8-button pads.
// Optional abort on a silent host: CONTROLLER_RESPONDER_TIMEOUT_EN.
module controller_responder
  import controller_pkg::*;
#(
  parameter int NUM_CONTROLLERS = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                         clk_in,
  input  logic                         rst,
  input  logic                         latch_in,
  input  logic                         ctrl_clk_in,
  input  logic [8*NUM_CONTROLLERS-1:0] buttons_in_LIST,
  output logic [NUM_CONTROLLERS-1:0]   data_B_LIST,
`ifdef CONTROLLER_RESPONDER_TIMEOUT_EN
  output logic                         timeout_pulse,
`endif
  output logic                         fetch_done
);

  localparam int BW = BUTTONS_PER_CONTROLLER;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       fetch_d;
  logic       sh_load, sh_shift, sh_clear;

  logic latch_lvl, latch_rise, latch_fall;
  logic clk_lvl, clk_rise, clk_fall;
  logic unused_sync;

  sync_edge_detect_m #(.STAGES(SYNC_STAGES)) u_latch_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (latch_in),
    .level  (latch_lvl),
    .rise   (latch_rise),
    .fall   (latch_fall)
  );

  sync_edge_detect_m #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (ctrl_clk_in),
    .level  (clk_lvl),
    .rise   (clk_rise),
    .fall   (clk_fall)
  );

  assign unused_sync = clk_lvl ^ clk_fall;

`ifdef CONTROLLER_RESPONDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_pulse_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fetch_d  = 1'b0;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_clear = 1'b0;
`ifdef CONTROLLER_RESPONDER_TIMEOUT_EN
    tmo_d       = tmo_q;
    tmo_pulse_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (latch_rise) begin
          state_d = LOAD;
          sh_load = 1'b1;
        end else if (clk_rise && !latch_lvl) begin
          sh_shift = 1'b1;
        end
      end
      LOAD: begin
        if (latch_fall) begin
          state_d = SHIFT;
          cnt_d   = 4'd0;
`ifdef CONTROLLER_RESPONDER_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else if (latch_lvl) begin
          sh_load = 1'b1;
        end
      end
      SHIFT: begin
        if (latch_rise) begin
          state_d = LOAD;
          sh_load = 1'b1;
          cnt_d   = 4'd0;
        end else if (clk_rise) begin
          sh_shift = 1'b1;
          cnt_d    = cnt_q + 4'd1;
`ifdef CONTROLLER_RESPONDER_TIMEOUT_EN
          tmo_d    = '0;
`endif
          if (cnt_q == 4'd7) begin
            fetch_d = 1'b1;
            state_d = IDLE;
          end
`ifdef CONTROLLER_RESPONDER_TIMEOUT_EN
        end else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
          state_d     = IDLE;
          sh_clear    = 1'b1;
          tmo_pulse_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      fetch_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fetch_done <= fetch_d;
    end
  end

`ifdef CONTROLLER_RESPONDER_TIMEOUT_EN
  always_ff @(posedge clk_in) begin
    if (rst) begin
      tmo_q         <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      tmo_q         <= tmo_d;
      timeout_pulse <= tmo_pulse_d;
    end
  end
`endif

  for (genvar k = 0; k < NUM_CONTROLLERS; k++) begin : g_pad
    logic [BW-1:0] sreg_q;

    always_ff @(posedge clk_in) begin
      if (rst || sh_clear) begin
        sreg_q <= '0;
      end else if (sh_load) begin
        sreg_q <= buttons_in_LIST[k*BW +: BW];
      end else if (sh_shift) begin
        sreg_q <= {sreg_q[BW-2:0], 1'b0};
      end
    end

    assign data_B_LIST[k] = ~sreg_q[BW-1];
  end

endmodule

// File: tb/tb_controller_responder.sv
// Directed bench: a host model latches and clocks the responder,
// reassembling each pad's byte from the active-low serial lines.
module tb_controller_responder;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        latch_in = 1'b0;
  logic        ctrl_clk_in = 1'b0;
  logic [15:0] buttons = 16'h0;
  logic [1:0]  data_b;
  logic        fetch_done;
`ifdef CONTROLLER_RESPONDER_TIMEOUT_EN
  logic        timeout_pulse;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_fetch = 0;
  int n_tmo = 0;

  controller_responder #(
    .NUM_CONTROLLERS (2),
    .SYNC_STAGES     (2),
    .TIMEOUT_CYCLES  (64)
  ) dut (
    .clk_in          (clk_in),
    .rst             (rst),
    .latch_in        (latch_in),
    .ctrl_clk_in     (ctrl_clk_in),
    .buttons_in_LIST (buttons),
    .data_B_LIST     (data_b),
`ifdef CONTROLLER_RESPONDER_TIMEOUT_EN
    .timeout_pulse   (timeout_pulse),
`endif
    .fetch_done      (fetch_done)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (!rst && fetch_done) n_fetch++;
`ifdef CONTROLLER_RESPONDER_TIMEOUT_EN
    if (!rst && timeout_pulse) n_tmo++;
`endif
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic latch_pulse();
    latch_in = 1'b1;
    wait_clk(6);
    latch_in = 1'b0;
    wait_clk(6);
  endtask

  // clk_in/16 host controller clock
  task automatic clk_pulse();
    ctrl_clk_in = 1'b1;
    wait_clk(8);
    ctrl_clk_in = 1'b0;
    wait_clk(8);
  endtask

  task automatic read_bits(input int nb,
                           inout logic [7:0] b0,
                           inout logic [7:0] b1);
    for (int i = 0; i < nb; i++) begin
      b0 = {b0[6:0], ~data_b[0]};
      b1 = {b1[6:0], ~data_b[1]};
      clk_pulse();
    end
  endtask

  initial begin
    logic [7:0] b0, b1;
    logic [7:0] r0, r1;
    int f0, t0;

    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    chk("reset_data", 32'(data_b), 32'h3);
    chk("reset_fetch", 32'(fetch_done), 32'h0);

    // basic frame, then one extra clock
    buttons = {8'h3C, 8'hA5};
    f0 = n_fetch;
    latch_pulse();
    b0 = 8'h0; b1 = 8'h0;
    read_bits(8, b0, b1);
    chk("frame_c0", 32'(b0), 32'hA5);
    chk("frame_c1", 32'(b1), 32'h3C);
    chk("frame_fetch", 32'(n_fetch - f0), 32'd1);
    chk("after8_data", 32'(data_b), 32'h3);
    clk_pulse();
    chk("ninth_data", 32'(data_b), 32'h3);
    chk("ninth_fetch", 32'(n_fetch - f0), 32'd1);

    // buttons change mid-shift
    f0 = n_fetch;
    latch_pulse();
    b0 = 8'h0; b1 = 8'h0;
    read_bits(3, b0, b1);
    buttons = 16'hFFFF;
    read_bits(5, b0, b1);
    chk("midchg_c0", 32'(b0), 32'hA5);
    chk("midchg_c1", 32'(b1), 32'h3C);
    chk("midchg_fetch", 32'(n_fetch - f0), 32'd1);

    // abort by latch after 4 clocks
    buttons = {8'h81, 8'h5A};
    f0 = n_fetch;
    latch_pulse();
    b0 = 8'h0; b1 = 8'h0;
    read_bits(4, b0, b1);
    buttons = {8'h18, 8'hC3};
    latch_pulse();
    chk("abort_nofetch", 32'(n_fetch - f0), 32'd0);
    b0 = 8'h0; b1 = 8'h0;
    read_bits(8, b0, b1);
    chk("abort_c0", 32'(b0), 32'hC3);
    chk("abort_c1", 32'(b1), 32'h18);
    chk("abort_fetch", 32'(n_fetch - f0), 32'd1);

    // latch fall and clock rise together: bit 7 still shown
    buttons = {8'h69, 8'h96};
    latch_in = 1'b1;
    wait_clk(6);
    latch_in = 1'b0;
    ctrl_clk_in = 1'b1;
    wait_clk(8);
    chk("same_bit7", 32'(data_b), 32'h2);
    ctrl_clk_in = 1'b0;
    wait_clk(8);
    b0 = 8'h0; b1 = 8'h0;
    read_bits(8, b0, b1);
    chk("same_c0", 32'(b0), 32'h96);
    chk("same_c1", 32'(b1), 32'h69);

    // reset in the middle of a transfer
    buttons = 16'h0000;
    latch_pulse();
    b0 = 8'h0; b1 = 8'h0;
    read_bits(3, b0, b1);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(2);
    chk("rst_mid_data", 32'(data_b), 32'h3);
    buttons = 16'h0000;
    clk_pulse();
    chk("rst_mid_clk", 32'(data_b), 32'h3);

    // random traffic through the host model
    for (int n = 0; n < 20; n++) begin
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      buttons = {r1, r0};
      latch_pulse();
      b0 = 8'h0; b1 = 8'h0;
      read_bits(8, b0, b1);
      chk($sformatf("rand%0d_c0", n), 32'(b0), 32'(r0));
      chk($sformatf("rand%0d_c1", n), 32'(b1), 32'(r1));
    end

`ifdef CONTROLLER_RESPONDER_TIMEOUT_EN
    chk("tmo_none_yet", 32'(n_tmo), 32'd0);
    buttons = 16'hFFFF;
    f0 = n_fetch;
    t0 = n_tmo;
    latch_pulse();
    clk_pulse();
    clk_pulse();
    chk("tmo_pending_data", 32'(data_b), 32'h0);
    wait_clk(80);
    chk("tmo_pulse", 32'(n_tmo - t0), 32'd1);
    chk("tmo_data", 32'(data_b), 32'h3);
    chk("tmo_nofetch", 32'(n_fetch - f0), 32'd0);
`else
    t0 = n_tmo;
    chk("no_tmo", 32'(t0), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
